scan_sel_ctrl4: RTL and testbench
=================================

Name: scan_sel_ctrl4

Overview:
- Sequential controller that drives the select and active-low enable inputs of the 2-to-4 active-low decoder (`de_selector14`).
- Round-robins over 4 slots (display digits / device selects), holding each for a dwell period.
- Inserts a blanking interval, with the decoder disabled, before every select change, so decoder outputs never glitch between slots.
- Slots can be skipped via a mask; the block sits directly upstream of the decoder.

Parameters:
- DWELL, 50000: cycles the decoder is enabled per slot (must be >= 1).
- BLANK, 16: cycles the decoder is disabled before each slot (must be >= 1).
- CW, 16: width of the shared dwell/blank counter; must hold max(DWELL,BLANK)-1.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iEn  in  1  run enable; 0 stops scanning.
- iMask  in  4  per-slot enable; bit k=1 means slot k is scanned.
- oS0  out  1  decoder iS0; equals slot[1] (MSB).
- oS1  out  1  decoder iS1; equals slot[0] (LSB).
- oC  out  1  decoder iC, active low; 0 means the decoder is driving a low output.
- oSlot  out  2  current slot index.
- oTick  out  1  one-cycle pulse on the first ACTIVE cycle of each slot.

Behaviour:
- All outputs are registered.
- Reset (iRst=1 at an edge), from any state, including mid-ACTIVE:
  - state=IDLE, oC=1, oSlot=0, oS0=0, oS1=0, oTick=0, counter=0.
  - Reset overrides all other inputs.
- States are IDLE, BLANK and ACTIVE.
- IDLE:
  - oC=1.
  - If iEn=1 and iMask!=0: go to BLANK. The slot is set to the lowest enabled index and the counter is cleared.
- BLANK:
  - oC=1.
  - The counter counts 0..BLANK-1. When it reaches BLANK-1, go to ACTIVE and clear the counter.
  - oTick=1 in the first ACTIVE cycle only.
- ACTIVE:
  - oC=0.
  - The counter counts 0..DWELL-1. When it reaches DWELL-1:
    - Go to BLANK.
    - Slot becomes the next enabled index after the current one, searching (slot+1..slot+3) mod 4, then the current slot itself.
  - With a single enabled slot, the same slot is reselected and a BLANK interval still occurs.
- Select changes:
  - oSlot, oS0 and oS1 change only on the edge entering BLANK from IDLE or ACTIVE.
  - They never change while oC=0 or within BLANK.
- Stop condition: iEn=0 or iMask==0 at an edge, in BLANK or ACTIVE.
  - Next state is IDLE with oC=1; oSlot is held.
  - This takes priority over the count terminal.
- Mask removal: the current slot's mask bit is cleared while in ACTIVE and the mask is otherwise nonzero.
  - Next state is BLANK with the next enabled slot and the counter cleared (early abort).
- Mask bits cleared during BLANK for the pending slot:
  - Take effect at the end of BLANK.
  - Re-run BLANK with the next enabled slot; oC stays 1.
- Latency: after IDLE exit, the first oC=0 occurs BLANK+1 edges after the iEn/iMask sample edge.
- Full period for N enabled slots is N*(BLANK+DWELL) cycles.
- Slot and counter arithmetic wrap mod 4 / mod CW; wrap from slot 3 to slot 0 needs no special case.

Decomposition:
- Shared package `scan_pkg`:
  - state encodings S_IDLE=2'd0, S_BLANK=2'd1, S_ACTIVE=2'd2.
  - slot-to-select mapping constants.
- One combinational sub-module `rr_next4`:
  - inputs: current slot[1:0], mask[3:0], include_self flag.
  - outputs: next slot[1:0], valid.
  - Reused for both the IDLE-exit (lowest enabled) search and the round-robin search.

Test Plan (DWELL=4, BLANK=2):
- Reset then iEn=1, iMask=4'b1111 sampled at edge 0:
  - oC=1 for edges 1-2, oC=0 for edges 3-6; oTick=1 at edge 3 only.
  - oSlot sequence 0,1,2,3,0 with 6-cycle spacing.
  - {oS0,oS1}: 00, 01, 10, 11.
- iMask=4'b1010:
  - oSlot alternates 1,3,1.
  - Slot 0 and slot 2 never appear.
  - Period is 12 cycles.
- iMask=4'b0100:
  - oSlot is constantly 2.
  - oC pattern repeats 1,1,0,0,0,0.
- iEn dropped at the 2nd ACTIVE cycle of slot 1:
  - Next edge: oC=1, state IDLE, oSlot=1 held.
  - Re-enable: restarts at slot 0 after a 2-cycle blank.
- Slot 2's mask bit cleared mid-ACTIVE with iMask becoming 4'b1011:
  - Next edge: oC=1, oSlot=3, counter restarted.
  - Verify oS0/oS1 never change while oC=0 across all cases.
- iRst asserted mid-ACTIVE with iEn held 1:
  - Next edge: all outputs at reset values.
  - After iRst deasserts, scanning restarts at slot 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan select controller: FSM state encodings and
// the mapping from slot index to decoder select pins.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } scanState_t;

  // Decoder iS0 carries the slot MSB, iS1 the slot LSB.
  localparam int SEL_S0_BIT = 1;
  localparam int SEL_S1_BIT = 0;

  // Searching forward from slot 3 with self included yields the lowest enabled slot.
  localparam logic [1:0] LOWEST_SEARCH_BASE = 2'd3;

endpackage

// File: rtl/scan_sel_ctrl4_rr_next4.sv
// Round-robin search over four slots: first enabled slot after curSlot
// (wrapping mod 4), falling back to curSlot itself when includeSelf is set.
module rr_next4 (
  input  logic [1:0] curSlot,
  input  logic [3:0] mask,
  input  logic       includeSelf,
  output logic [1:0] nextSlot,
  output logic       valid
);

  always_comb begin
    logic [1:0] cand;
    // NOTE: every output gets a default before any branch; a path that leaves
    // a combinational output unassigned infers a latch.
    nextSlot = curSlot;
    valid    = 1'b0;
    cand     = curSlot;
    for (int i = 1; i < 4; i++) begin
      cand = curSlot + 2'(i);
      if (!valid && mask[cand]) begin
        nextSlot = cand;
        valid    = 1'b1;
      end
    end
    if (!valid && includeSelf && mask[curSlot]) begin
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/scan_sel_ctrl4.sv
// Round-robin select/enable driver for a 2-to-4 active-low decoder, with a
// blanking interval (decoder disabled) ahead of every slot.
module scan_sel_ctrl4
  import scan_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int BLANK = 16,
  parameter int CW    = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEn,
  input  logic [3:0] iMask,
  output logic       oS0,
  output logic       oS1,
  output logic       oC,
  output logic [1:0] oSlot,
  output logic       oTick
);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  scanState_t    stateQ, stateD;
  logic [CW-1:0] cntQ, cntD;
  logic [1:0]    slotQ, slotD;
  logic [1:0]    searchBase, nextSlot;
  logic          nextValid, runOk;

  // One search unit serves both IDLE exit (lowest enabled) and round-robin advance.
  assign searchBase = (stateQ == S_IDLE) ? LOWEST_SEARCH_BASE : slotQ;

  rr_next4 uNext (
    .curSlot    (searchBase),
    .mask       (iMask),
    .includeSelf(1'b1),
    .nextSlot   (nextSlot),
    .valid      (nextValid)
  );

  // With self included, a valid search result is equivalent to a nonzero mask.
  assign runOk = iEn && nextValid;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ + 1'b1;
    slotD  = slotQ;
    unique case (stateQ)
      S_IDLE: begin
        cntD = '0;
        if (runOk) begin
          stateD = S_BLANK;
          slotD  = nextSlot;
        end
      end
      S_BLANK: begin
        if (!runOk) begin
          stateD = S_IDLE;
          cntD   = '0;
        end else if (cntQ == BLANK_LAST) begin
          cntD = '0;
          // A pending slot disabled during blanking costs another full blank.
          if (iMask[slotQ]) stateD = S_ACTIVE;
          else              slotD  = nextSlot;
        end
      end
      S_ACTIVE: begin
        if (!runOk) begin
          stateD = S_IDLE;
          cntD   = '0;
        end else if (!iMask[slotQ] || cntQ == DWELL_LAST) begin
          stateD = S_BLANK;
          slotD  = nextSlot;
          cntD   = '0;
        end
      end
      default: begin
        stateD = S_IDLE;
        cntD   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ <= S_IDLE;
      cntQ   <= '0;
      slotQ  <= '0;
      oC     <= 1'b1;
      oTick  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      slotQ  <= slotD;
      oC     <= (stateD != S_ACTIVE);
      oTick  <= (stateQ == S_BLANK) && (stateD == S_ACTIVE);
    end
  end

  assign oSlot = slotQ;
  assign oS0   = slotQ[SEL_S0_BIT];
  assign oS1   = slotQ[SEL_S1_BIT];

endmodule

// File: tb/tb_scan_sel_ctrl4.sv
// Self-checking bench for scan_sel_ctrl4 at DWELL=4, BLANK=2: a literal vector
// table for reset and start-up, then scan-pattern sequences through a scoreboard.
module tb_scan_sel_ctrl4;

  localparam int TB_DWELL = 4;
  localparam int TB_BLANK = 2;
  localparam int PERIOD   = TB_DWELL + TB_BLANK;

  logic       iClk, iRst, iEn;
  logic [3:0] iMask;
  logic       oS0, oS1, oC, oTick;
  logic [1:0] oSlot;

  scan_sel_ctrl4 #(.DWELL(TB_DWELL), .BLANK(TB_BLANK), .CW(4)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .iEn  (iEn),
    .iMask(iMask),
    .oS0  (oS0),
    .oS1  (oS1),
    .oC   (oC),
    .oSlot(oSlot),
    .oTick(oTick)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic       c;
    logic [1:0] slot;
    logic       tick;
  } vec_t;

  typedef struct {
    logic       c;
    logic [1:0] slot;
    logic       tick;
  } exp_t;

  exp_t       sbQ[$];
  vec_t       vecs[14];
  int         vecCount  = 0;
  int         missCount = 0;
  logic [1:0] heldSlot  = 2'd0;
  logic [1:0] prevSel   = 2'b00;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, and compare just after the edge.
  task automatic step(input logic rst, input logic en, input logic [3:0] mask,
                      input logic expC, input logic [1:0] expSlot, input logic expTick,
                      input string name);
    exp_t e;
    logic selGlitch;
    iRst  = rst;
    iEn   = en;
    iMask = mask;
    e.c = expC; e.slot = expSlot; e.tick = expTick;
    sbQ.push_back(e);
    heldSlot = expSlot;
    @(posedge iClk);
    #1;
    e = sbQ.pop_front();
    check(name, {oTick, oC, oS0, oS1, oSlot},
          {e.tick, e.c, e.slot[1], e.slot[0], e.slot});
    selGlitch = (oC == 1'b0) && ({oS0, oS1} != prevSel);
    check($sformatf("%s_selStable", name), {5'b0, selGlitch}, 6'd0);
    prevSel = {oS0, oS1};
  endtask

  // Expected scan: enabled slots in cyclic order from startSlot, each PERIOD
  // cycles long (BLANK cycles with oC=1, then DWELL with oC=0, tick on the first).
  task automatic scanSteps(input logic [3:0] mask, input logic [1:0] startSlot,
                           input int startK, input int n, input string name);
    logic [1:0] order[$];
    logic [1:0] s;
    for (int i = 0; i < 4; i++) begin
      s = startSlot + 2'(i);
      if (mask[s]) order.push_back(s);
    end
    for (int k = startK; k < startK + n; k++) begin
      int ph = k % PERIOD;
      step(1'b0, 1'b1, mask, ph < TB_BLANK, order[(k / PERIOD) % order.size()],
           ph == TB_BLANK, $sformatf("%s[%0d]", name, k));
    end
  endtask

  initial begin
    iRst = 1'b1; iEn = 1'b0; iMask = 4'h0;

    //          rst   en    mask   c     slot  tick
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 1'b1, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'hF, 1'b1, 2'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'hF, 1'b0, 2'd1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mask, vecs[i].c, vecs[i].slot,
           vecs[i].tick, $sformatf("vec[%0d]", i));
    end

    // Remainder of the 4-slot scan: slots 2, 3, back to 0, into slot 1's 2nd active cycle.
    scanSteps(4'hF, 2'd0, 12, 22, "all4");

    // Drop iEn mid-ACTIVE: IDLE with slot held, then restart from slot 0.
    step(1'b0, 1'b0, 4'hF, 1'b1, 2'd1, 1'b0, "stopActive");
    step(1'b0, 1'b0, 4'hF, 1'b1, 2'd1, 1'b0, "idleHold");
    scanSteps(4'hF, 2'd0, 0, 8, "restart");

    // Stop from BLANK, then alternate slots 1 and 3.
    step(1'b0, 1'b0, 4'hF, 1'b1, heldSlot, 1'b0, "stopBlank");
    scanSteps(4'b1010, 2'd0, 0, 30, "mask1010");

    // Single enabled slot still blanks between dwells.
    step(1'b0, 1'b0, 4'hF, 1'b1, heldSlot, 1'b0, "stop1010");
    scanSteps(4'b0100, 2'd0, 0, 18, "mask0100");

    // Slot 2's bit cleared during its BLANK: blank completes, then re-blanks on slot 3.
    step(1'b0, 1'b0, 4'hF, 1'b1, heldSlot, 1'b0, "stop0100");
    scanSteps(4'hF, 2'd0, 0, 13, "preBlankClr");
    step(1'b0, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b0, "blankClrHold");
    scanSteps(4'b1011, 2'd3, 0, 8, "blankClrRerun");

    // Slot 2's bit cleared in its first ACTIVE cycle: immediate abort to slot 3.
    step(1'b0, 1'b0, 4'hF, 1'b1, heldSlot, 1'b0, "stopPreAbort");
    scanSteps(4'hF, 2'd0, 0, 15, "preAbort");
    scanSteps(4'b1011, 2'd3, 0, 16, "abort");

    // Reset mid-ACTIVE of slot 1 with iEn held, then restart from slot 0.
    step(1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b0, "rstMid");
    scanSteps(4'hF, 2'd0, 0, 8, "afterRst");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
